angle_frame_rx: RTL and testbench

Command-framing stage between the `uart_rx` receiver and the `modulator`. After each rising edge of `shoot`, it assembles a multi-byte UART frame into a 12-bit angle and validates parity, range, reserved bits and inter-byte timing. It commits the angle atomically, so the modulator never sees a half-updated word. Bad frames are discarded, counted and flagged.

---
 rtl/angle_frame_rx_pkg.sv | 17 +
 rtl/angle_frame_rx_edge_sync.sv | 28 ++
 rtl/angle_frame_rx.sv | 166 ++++++++++++++++
 tb/tb_angle_frame_rx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/angle_frame_rx_pkg.sv
// Shared definitions for the angle frame receiver: state encodings, checksum seed, reserved-bit mask.
// ANGLE_FRAME_CHECKSUM_EN selects the 3-byte checksummed frame format.
package angle_frame_rx_pkg;

  localparam logic [2:0] ST_IDLE    = 3'b000;
  localparam logic [2:0] ST_WAIT_LO = 3'b001;
  localparam logic [2:0] ST_WAIT_HI = 3'b010;
  localparam logic [2:0] ST_WAIT_CK = 3'b011;

  localparam logic [7:0]  CK_SEED       = 8'h5A;
  localparam logic [15:0] RESERVED_MASK = 16'hF000;

  function automatic logic [7:0] frame_checksum(input logic [7:0] b0, input logic [7:0] b1);
    return b0 ^ b1 ^ CK_SEED;
  endfunction

endpackage

// File: rtl/angle_frame_rx_edge_sync.sv
// Two-flop synchronizer with a rising-edge pulse output; shared by GPIO-style async inputs.
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_rise = r_sync2 & ~r_prev;

endmodule

// File: rtl/angle_frame_rx.sv
// UART command framer: assembles, validates and atomically commits a 12-bit angle after each shoot edge.
// Define ANGLE_FRAME_CHECKSUM_EN for the 3-byte frame with an XOR checksum byte.
module angle_frame_rx
  import angle_frame_rx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 24000,
  parameter int ANGLE_MAX      = 3599
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  input  logic        parity_error,
  input  logic        shoot,
  output logic [11:0] angle,
  output logic        angle_valid,
  output logic        angle_update,
  output logic        frame_error,
  output logic [7:0]  err_count,
  output logic [2:0]  state_dbg
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [11:0]   ANGLE_MAX_L  = 12'(ANGLE_MAX);

  logic [2:0]    r_state;
  logic [TW-1:0] r_timer;
  logic [7:0]    r_stage_lo;
  logic [11:0]   r_angle;
  logic          r_angle_valid;
  logic          r_angle_update;
  logic          r_frame_error;
  logic [7:0]    r_err_count;

  logic          w_shoot_rise;
  logic          w_in_wait;
  logic [15:0]   w_word;
  logic          w_word_bad;
  logic [2:0]    w_next_state;
  logic          w_reject;
  logic          w_commit;
  logic          w_timer_clr;
  logic          w_store_lo;
  logic [11:0]   w_commit_angle;

  edge_sync u_shoot_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (shoot),
    .o_rise  (w_shoot_rise)
  );

  assign w_in_wait  = (r_state == ST_WAIT_LO) || (r_state == ST_WAIT_HI) || (r_state == ST_WAIT_CK);
  assign w_word     = {rx_data, r_stage_lo};
  assign w_word_bad = ((w_word & RESERVED_MASK) != 16'h0000) || (w_word[11:0] > ANGLE_MAX_L);

`ifdef ANGLE_FRAME_CHECKSUM_EN
  logic [7:0] r_stage_hi;
  logic       w_store_hi;

  assign w_store_hi = (r_state == ST_WAIT_HI) && (w_next_state == ST_WAIT_CK);

  always_ff @(posedge clk) begin
    if (!reset)          r_stage_hi <= 8'h00;
    else if (w_store_hi) r_stage_hi <= rx_data;
  end
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next_state   = r_state;
    w_reject       = 1'b0;
    w_commit       = 1'b0;
    w_timer_clr    = 1'b0;
    w_store_lo     = 1'b0;
    w_commit_angle = w_word[11:0];
    if (r_state == ST_IDLE) begin
      if (w_shoot_rise) begin
        w_next_state = ST_WAIT_LO;
        w_timer_clr  = 1'b1;
      end
    end else if (!w_in_wait) begin
      w_next_state = ST_IDLE;
    end else if (w_shoot_rise) begin
      // A re-arm abandons the partial frame and drops any byte landing in the same cycle.
      w_reject     = 1'b1;
      w_next_state = ST_WAIT_LO;
      w_timer_clr  = 1'b1;
    end else if (rx_done) begin
      w_timer_clr = 1'b1;
      case (r_state)
        ST_WAIT_LO: begin
          if (parity_error) begin
            w_reject     = 1'b1;
            w_next_state = ST_IDLE;
          end else begin
            w_store_lo   = 1'b1;
            w_next_state = ST_WAIT_HI;
          end
        end
        ST_WAIT_HI: begin
          if (parity_error || w_word_bad) begin
            w_reject     = 1'b1;
            w_next_state = ST_IDLE;
          end else begin
`ifdef ANGLE_FRAME_CHECKSUM_EN
            w_next_state = ST_WAIT_CK;
`else
            w_commit     = 1'b1;
            w_next_state = ST_IDLE;
`endif
          end
        end
        default: begin
          w_next_state = ST_IDLE;
`ifdef ANGLE_FRAME_CHECKSUM_EN
          w_commit_angle = {r_stage_hi[3:0], r_stage_lo};
          if (parity_error || (rx_data != frame_checksum(r_stage_lo, r_stage_hi))) begin
            w_reject = 1'b1;
          end else begin
            w_commit = 1'b1;
          end
`else
          w_reject = 1'b1;
`endif
        end
      endcase
    end else if (r_timer == TIMEOUT_LAST) begin
      w_reject     = 1'b1;
      w_next_state = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_timer        <= '0;
      r_stage_lo     <= 8'h00;
      r_angle        <= 12'h000;
      r_angle_valid  <= 1'b0;
      r_angle_update <= 1'b0;
      r_frame_error  <= 1'b0;
      r_err_count    <= 8'h00;
    end else begin
      r_state        <= w_next_state;
      r_timer        <= (w_timer_clr || (w_next_state == ST_IDLE)) ? '0 : r_timer + 1'b1;
      r_angle_update <= w_commit;
      r_frame_error  <= w_reject;
      if (w_store_lo) r_stage_lo <= rx_data;
      if (w_commit) begin
        r_angle       <= w_commit_angle;
        r_angle_valid <= 1'b1;
      end
      if (w_reject && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 1'b1;
    end
  end

  assign angle        = r_angle;
  assign angle_valid  = r_angle_valid;
  assign angle_update = r_angle_update;
  assign frame_error  = r_frame_error;
  assign err_count    = r_err_count;
  assign state_dbg    = r_state;

endmodule

// File: tb/tb_angle_frame_rx.sv
// Directed self-checking bench for angle_frame_rx; covers the checksum build when ANGLE_FRAME_CHECKSUM_EN is defined.
module tb_angle_frame_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        parity_error;
  logic        shoot;
  logic [11:0] angle;
  logic        angle_valid;
  logic        angle_update;
  logic        frame_error;
  logic [7:0]  err_count;
  logic [2:0]  state_dbg;

  int checks   = 0;
  int failures = 0;

  angle_frame_rx dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_done      (rx_done),
    .parity_error (parity_error),
    .shoot        (shoot),
    .angle        (angle),
    .angle_valid  (angle_valid),
    .angle_update (angle_update),
    .frame_error  (frame_error),
    .err_count    (err_count),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic perr);
    rx_data      = b;
    rx_done      = 1'b1;
    parity_error = perr;
    tick(1);
    rx_done      = 1'b0;
    parity_error = 1'b0;
  endtask

  // Shoot low long enough to clear the synchronizer, then rise; leaves IDLE on the 3rd edge.
  task automatic arm(input string tag);
    shoot = 1'b0;
    tick(3);
    shoot = 1'b1;
    tick(2);
    check({tag, "_state_pre"}, state_dbg, 3'd0);
    tick(1);
    check({tag, "_state_lo"}, state_dbg, 3'd1);
  endtask

  initial begin
    reset        = 1'b0;
    rx_data      = 8'h00;
    rx_done      = 1'b0;
    parity_error = 1'b0;
    shoot        = 1'b0;
    tick(3);
    check("rst_angle",  angle,        12'h000);
    check("rst_valid",  angle_valid,  1'b0);
    check("rst_update", angle_update, 1'b0);
    check("rst_ferr",   frame_error,  1'b0);
    check("rst_errc",   err_count,    8'd0);
    check("rst_state",  state_dbg,    3'd0);
    reset = 1'b1;
    tick(1);

`ifndef ANGLE_FRAME_CHECKSUM_EN
    // Good frame 0x12C
    arm("t1");
    send_byte(8'h2C, 1'b0);
    check("t1_state_hi", state_dbg, 3'd2);
    send_byte(8'h01, 1'b0);
    check("t1_angle",  angle,        12'h12C);
    check("t1_update", angle_update, 1'b1);
    check("t1_valid",  angle_valid,  1'b1);
    check("t1_errc",   err_count,    8'd0);
    check("t1_state",  state_dbg,    3'd0);
    tick(1);
    check("t1_update_end", angle_update, 1'b0);

    // Out-of-range candidate 3600
    arm("t2");
    send_byte(8'h10, 1'b0);
    send_byte(8'h0E, 1'b0);
    check("t2_ferr",   frame_error,  1'b1);
    check("t2_errc",   err_count,    8'd1);
    check("t2_angle",  angle,        12'h12C);
    check("t2_update", angle_update, 1'b0);
    check("t2_state",  state_dbg,    3'd0);
    tick(1);
    check("t2_ferr_end", frame_error, 1'b0);

    // Timeout after byte 0
    arm("t3");
    send_byte(8'h05, 1'b0);
    tick(23999);
    check("t3_state_before", state_dbg,   3'd2);
    check("t3_ferr_before",  frame_error, 1'b0);
    tick(1);
    check("t3_ferr",  frame_error, 1'b1);
    check("t3_state", state_dbg,   3'd0);
    check("t3_errc",  err_count,   8'd2);
    send_byte(8'h07, 1'b0);
    check("t3_idle_state",  state_dbg,    3'd0);
    check("t3_idle_errc",   err_count,    8'd2);
    check("t3_idle_ferr",   frame_error,  1'b0);
    check("t3_idle_update", angle_update, 1'b0);

    // Parity error on byte 1, then a good zero frame
    arm("t4");
    send_byte(8'h11, 1'b0);
    send_byte(8'h01, 1'b1);
    check("t4_ferr",  frame_error, 1'b1);
    check("t4_errc",  err_count,   8'd3);
    check("t4_angle", angle,       12'h12C);
    arm("t4b");
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    check("t4_zero_angle",  angle,        12'h000);
    check("t4_zero_update", angle_update, 1'b1);

    // Re-arm colliding with rx_done
    arm("t5");
    send_byte(8'h2C, 1'b0);
    shoot = 1'b0;
    tick(3);
    shoot = 1'b1;
    tick(2);
    rx_data = 8'h01;
    rx_done = 1'b1;
    tick(1);
    rx_done = 1'b0;
    check("t5_ferr",   frame_error,  1'b1);
    check("t5_errc",   err_count,    8'd4);
    check("t5_state",  state_dbg,    3'd1);
    check("t5_update", angle_update, 1'b0);
    check("t5_angle",  angle,        12'h000);

    // 300 forced rejects by repeated re-arm; each rise is sampled one edge into the next period
    for (int i = 0; i < 300; i++) begin
      shoot = 1'b0;
      tick(2);
      shoot = 1'b1;
      tick(2);
    end
    tick(1);
    check("t5_sat_errc",  err_count,   8'd255);
    check("t5_sat_ferr",  frame_error, 1'b1);
    check("t5_sat_state", state_dbg,   3'd1);
    shoot = 1'b0;

    // Reset mid-frame discards without counting
    send_byte(8'h05, 1'b0);
    check("t6_state_hi", state_dbg, 3'd2);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    check("t6_state", state_dbg,   3'd0);
    check("t6_errc",  err_count,   8'd0);
    check("t6_valid", angle_valid, 1'b0);
    check("t6_ferr",  frame_error, 1'b0);
`else
    // Checksummed frame: 0x2C ^ 0x01 ^ 0x5A = 0x77
    arm("c1");
    send_byte(8'h2C, 1'b0);
    send_byte(8'h01, 1'b0);
    check("c1_state_ck", state_dbg,    3'd3);
    check("c1_no_update", angle_update, 1'b0);
    send_byte(8'h77, 1'b0);
    check("c1_angle",  angle,        12'h12C);
    check("c1_update", angle_update, 1'b1);
    check("c1_valid",  angle_valid,  1'b1);
    check("c1_state",  state_dbg,    3'd0);

    arm("c2");
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h76, 1'b0);
    check("c2_ferr",   frame_error,  1'b1);
    check("c2_errc",   err_count,    8'd1);
    check("c2_angle",  angle,        12'h12C);
    check("c2_update", angle_update, 1'b0);
    check("c2_state",  state_dbg,    3'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
